// File: rtl/traffic_lamp_conflict_monitor_pkg.sv
// Shared encodings for the lamp conflict monitor: light codes, fault codes,
// monitor states and direction indices.
package traffic_lamp_conflict_monitor_pkg;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] DARK   = 3'b000;

  localparam logic [2:0] FC_NONE           = 3'd0;
  localparam logic [2:0] FC_INVALID        = 3'd1;
  localparam logic [2:0] FC_CONFLICT       = 3'd2;
  localparam logic [2:0] FC_GO_TIMEOUT     = 3'd3;
  localparam logic [2:0] FC_ALLRED_TIMEOUT = 3'd4;

  typedef enum logic [1:0] {
    MONITOR = 2'd0,
    FAULT   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  // Element i holds the light vector of direction index i.
  typedef logic [3:0][2:0] lamp_set_t;

  localparam lamp_set_t ALL_RED  = {4{RED}};
  localparam lamp_set_t ALL_DARK = {4{DARK}};

  function automatic logic light_valid(input logic [2:0] l);
    return (l == RED) || (l == YELLOW) || (l == GREEN);
  endfunction

endpackage

// File: rtl/traffic_lamp_conflict_monitor_lamp_pattern_checker.sv
// Combinational classification of a four-direction light pattern:
// illegal encodings, multiple go-phases, all-red, and the active direction.
module lamp_pattern_checker
  import traffic_lamp_conflict_monitor_pkg::*;
(
  input  lamp_set_t  pattern,
  output logic       invalid,
  output logic       conflict,
  output logic       all_red,
  output logic [1:0] active_dir
);

  logic [2:0] nonred_cnt;
  logic       found;

  always_comb begin
    invalid    = 1'b0;
    nonred_cnt = '0;
    found      = 1'b0;
    active_dir = DIR_N;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!light_valid(pattern[i])) invalid = 1'b1;
      if (pattern[i] != RED) begin
        nonred_cnt = nonred_cnt + 3'd1;
        if (!found) begin
          active_dir = 2'(i);
          found      = 1'b1;
        end
      end
    end
    all_red  = (nonred_cnt == 3'd0);
    conflict = (nonred_cnt > 3'd1);
  end

endmodule

// File: rtl/traffic_lamp_conflict_monitor.sv
// Safety stage between the traffic light controller and the lamps: two-stage
// pass-through with masking, fault latching, all-red flashing and recovery.
module traffic_lamp_conflict_monitor
  import traffic_lamp_conflict_monitor_pkg::*;
#(
  parameter int unsigned PERSIST     = 2,
  parameter int unsigned MAX_GO      = 48,
  parameter int unsigned MAX_ALLRED  = 24,
  parameter int unsigned FLASH_HALF  = 8,
  parameter int unsigned RECOVER_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] north_lights,
  input  logic [2:0] east_lights,
  input  logic [2:0] south_lights,
  input  logic [2:0] west_lights,
  input  logic       clear,
  output logic [2:0] north_lamp,
  output logic [2:0] east_lamp,
  output logic [2:0] south_lamp,
  output logic [2:0] west_lamp,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int unsigned DW = $clog2(MAX_GO + 2);
  localparam int unsigned AW = $clog2(MAX_ALLRED + 2);
  localparam int unsigned FW = $clog2(2 * FLASH_HALF);
  localparam int unsigned RW = $clog2(RECOVER_CYC + 1);

  localparam logic [3:0]    PERSIST_L = 4'(PERSIST);
  localparam logic [DW-1:0] GO_LIM    = DW'(MAX_GO);
  localparam logic [DW-1:0] GO_SAT    = DW'(MAX_GO + 1);
  localparam logic [AW-1:0] AR_LIM    = AW'(MAX_ALLRED);
  localparam logic [AW-1:0] AR_SAT    = AW'(MAX_ALLRED + 1);
  localparam logic [FW-1:0] FL_HALF   = FW'(FLASH_HALF);
  localparam logic [FW-1:0] FL_LAST   = FW'(2 * FLASH_HALF - 1);
  localparam logic [RW-1:0] REC_LAST  = RW'(RECOVER_CYC - 1);

  state_t        state_q, state_n;
  lamp_set_t     in_d, in_q, lamps_q, lamps_n;
  logic [3:0]    pcnt_q, pcnt_n, pcnt_inc;
  logic [DW-1:0] dwell_q, dwell_n, dwell_now;
  logic [AW-1:0] allred_q, allred_n, allred_now;
  logic [1:0]    dir_q, dir_n;
  logic [FW-1:0] flash_q, flash_n;
  logic [RW-1:0] rec_q, rec_n;
  logic          fault_q, fault_n;
  logic [2:0]    code_q, code_n, code_now;
  logic          invalid, conflict, all_red, single_go;
  logic [1:0]    active_dir;

  assign in_d = {west_lights, south_lights, east_lights, north_lights};

  lamp_pattern_checker u_checker (
    .pattern    (in_q),
    .invalid    (invalid),
    .conflict   (conflict),
    .all_red    (all_red),
    .active_dir (active_dir)
  );

  always_comb begin
    single_go = !invalid && !conflict && !all_red;

    if (!single_go)
      dwell_now = '0;
    else if ((dwell_q != '0) && (active_dir == dir_q))
      dwell_now = (dwell_q == GO_SAT) ? GO_SAT : dwell_q + DW'(1);
    else
      dwell_now = DW'(1);

    if (!all_red)
      allred_now = '0;
    else
      allred_now = (allred_q == AR_SAT) ? AR_SAT : allred_q + AW'(1);

    if (invalid)
      code_now = FC_INVALID;
    else if (conflict)
      code_now = FC_CONFLICT;
    else if (dwell_now > GO_LIM)
      code_now = FC_GO_TIMEOUT;
    else if ((state_q == MONITOR) && (allred_now > AR_LIM))
      code_now = FC_ALLRED_TIMEOUT;
    else
      code_now = FC_NONE;

    pcnt_inc = (pcnt_q == PERSIST_L) ? pcnt_q : pcnt_q + 4'd1;
  end

  // Lamps are loaded from the next state/flash value so the red phase is
  // already on the lamps during the first cycle spent in FAULT.
  always_comb begin
    state_n  = state_q;
    pcnt_n   = '0;
    dwell_n  = '0;
    allred_n = '0;
    dir_n    = active_dir;
    flash_n  = flash_q;
    rec_n    = rec_q;
    fault_n  = fault_q;
    code_n   = code_q;
    lamps_n  = ALL_RED;

    unique case (state_q)
      MONITOR: begin
        dwell_n  = dwell_now;
        allred_n = allred_now;
        if (code_now != FC_NONE) begin
          if (pcnt_inc == PERSIST_L) begin
            state_n  = FAULT;
            fault_n  = 1'b1;
            code_n   = code_now;
            flash_n  = '0;
            dwell_n  = '0;
            allred_n = '0;
          end else begin
            pcnt_n = pcnt_inc;
          end
        end else begin
          lamps_n = in_q;
        end
      end

      FAULT: begin
        flash_n = (flash_q == FL_LAST) ? '0 : flash_q + FW'(1);
        if (clear && all_red) begin
          state_n = RECOVER;
          rec_n   = '0;
        end else begin
          lamps_n = (flash_n < FL_HALF) ? ALL_RED : ALL_DARK;
        end
      end

      RECOVER: begin
        if (!all_red) begin
          state_n = FAULT;
          flash_n = '0;
        end else if (rec_q == REC_LAST) begin
          state_n = MONITOR;
          fault_n = 1'b0;
          code_n  = FC_NONE;
          rec_n   = '0;
          flash_n = '0;
          lamps_n = in_q;
        end else begin
          rec_n = rec_q + RW'(1);
        end
      end

      default: begin
        state_n = MONITOR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= MONITOR;
      in_q     <= ALL_RED;
      lamps_q  <= ALL_RED;
      pcnt_q   <= '0;
      dwell_q  <= '0;
      allred_q <= '0;
      dir_q    <= DIR_N;
      flash_q  <= '0;
      rec_q    <= '0;
      fault_q  <= 1'b0;
      code_q   <= FC_NONE;
    end else begin
      state_q  <= state_n;
      in_q     <= in_d;
      lamps_q  <= lamps_n;
      pcnt_q   <= pcnt_n;
      dwell_q  <= dwell_n;
      allred_q <= allred_n;
      dir_q    <= dir_n;
      flash_q  <= flash_n;
      rec_q    <= rec_n;
      fault_q  <= fault_n;
      code_q   <= code_n;
    end
  end

  assign north_lamp = lamps_q[DIR_N];
  assign east_lamp  = lamps_q[DIR_E];
  assign south_lamp = lamps_q[DIR_S];
  assign west_lamp  = lamps_q[DIR_W];
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_traffic_lamp_conflict_monitor.sv
// Directed bench for the lamp conflict monitor with a behavioural reference
// model compared every cycle plus hand-computed spot checks.
module tb_traffic_lamp_conflict_monitor;

  localparam int PERSIST     = 2;
  localparam int MAX_GO      = 48;
  localparam int MAX_ALLRED  = 24;
  localparam int FLASH_HALF  = 8;
  localparam int RECOVER_CYC = 16;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] D = 3'b000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] nl = R, el = R, sl = R, wl = R;
  logic       clear = 1'b0;
  logic [2:0] n_lamp, e_lamp, s_lamp, w_lamp;
  logic       fault;
  logic [2:0] fault_code;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  traffic_lamp_conflict_monitor #(
    .PERSIST     (PERSIST),
    .MAX_GO      (MAX_GO),
    .MAX_ALLRED  (MAX_ALLRED),
    .FLASH_HALF  (FLASH_HALF),
    .RECOVER_CYC (RECOVER_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .north_lights (nl),
    .east_lights  (el),
    .south_lights (sl),
    .west_lights  (wl),
    .clear        (clear),
    .north_lamp   (n_lamp),
    .east_lamp    (e_lamp),
    .south_lamp   (s_lamp),
    .west_lamp    (w_lamp),
    .fault        (fault),
    .fault_code   (fault_code)
  );

  // ---------------- reference model ----------------
  int m_in[4];
  int m_lamp[4];
  int m_fault, m_code;
  int viol_run, go_run, go_dir, red_run;
  int age, recovering, rec_seen;
  int nr, inv, d, ar, code;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        m_in[i]   = 4;
        m_lamp[i] = 4;
      end
      m_fault = 0; m_code = 0;
      viol_run = 0; go_run = 0; go_dir = 0; red_run = 0;
      age = 0; recovering = 0; rec_seen = 0;
    end else begin
      nr = 0; inv = 0; d = 0;
      for (int i = 3; i >= 0; i--) begin
        if (!(m_in[i] == 4 || m_in[i] == 2 || m_in[i] == 1)) inv = 1;
        if (m_in[i] != 4) begin
          nr = nr + 1;
          d  = i;
        end
      end
      ar = (nr == 0) ? 1 : 0;
      if (m_fault == 0) begin
        if (inv == 0 && nr == 1)
          go_run = (go_run > 0 && d == go_dir) ? go_run + 1 : 1;
        else
          go_run = 0;
        go_dir = d;
        if (go_run > MAX_GO + 1) go_run = MAX_GO + 1;
        red_run = (ar != 0) ? red_run + 1 : 0;
        if (red_run > MAX_ALLRED + 1) red_run = MAX_ALLRED + 1;
        code = (inv != 0) ? 1 : (nr > 1) ? 2 : (go_run > MAX_GO) ? 3 :
               (red_run > MAX_ALLRED) ? 4 : 0;
        if (code != 0) begin
          viol_run = viol_run + 1;
          for (int i = 0; i < 4; i++) m_lamp[i] = 4;
          if (viol_run >= PERSIST) begin
            m_fault = 1; m_code = code; age = 0; recovering = 0;
            viol_run = 0; go_run = 0; red_run = 0;
          end
        end else begin
          viol_run = 0;
          for (int i = 0; i < 4; i++) m_lamp[i] = m_in[i];
        end
      end else if (recovering == 0) begin
        age = age + 1;
        if (clear && ar != 0) begin
          recovering = 1; rec_seen = 0;
          for (int i = 0; i < 4; i++) m_lamp[i] = 4;
        end else begin
          for (int i = 0; i < 4; i++)
            m_lamp[i] = ((age % (2 * FLASH_HALF)) < FLASH_HALF) ? 4 : 0;
        end
      end else begin
        for (int i = 0; i < 4; i++) m_lamp[i] = 4;
        if (ar == 0) begin
          recovering = 0; age = 0;
        end else begin
          rec_seen = rec_seen + 1;
          if (rec_seen == RECOVER_CYC) begin
            m_fault = 0; m_code = 0; recovering = 0;
          end
        end
      end
      m_in[0] = int'(nl); m_in[1] = int'(el); m_in[2] = int'(sl); m_in[3] = int'(wl);
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [14:0] act_vec, exp_vec;
  always @(negedge clk) begin
    act_vec = {n_lamp, e_lamp, s_lamp, w_lamp, fault, fault_code[1:0]};
    exp_vec = {3'(m_lamp[0]), 3'(m_lamp[1]), 3'(m_lamp[2]), 3'(m_lamp[3]),
               1'(m_fault), 2'(m_code)};
    checks = checks + 1;
    if (act_vec !== exp_vec || fault_code[2] !== 1'(m_code >> 2)) begin
      failures = failures + 1;
      $display("FAIL model_compare t=%0t lamps=%b_%b_%b_%b fault=%b code=%0d required lamps=%0d_%0d_%0d_%0d fault=%0d code=%0d",
               $time, n_lamp, e_lamp, s_lamp, w_lamp, fault, fault_code,
               m_lamp[0], m_lamp[1], m_lamp[2], m_lamp[3], m_fault, m_code);
    end
  end

  // ---------------- helpers ----------------
  task automatic lit(input string name, input logic [11:0] act, input logic [11:0] req);
    checks = checks + 1;
    if (act !== req) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic hold(input logic [2:0] n, input logic [2:0] e, input logic [2:0] s,
                      input logic [2:0] w, input logic c, input int cyc);
    nl = n; el = e; sl = s; wl = w; clear = c;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic do_reset(input string name);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    lit({name, "_lamps"}, {n_lamp, e_lamp, s_lamp, w_lamp}, {R, R, R, R});
    lit({name, "_fault"}, {8'd0, fault, fault_code}, 12'd0);
    nl = R; el = R; sl = R; wl = R; clear = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (2) @(negedge clk);
    lit("reset_lamps", {n_lamp, e_lamp, s_lamp, w_lamp}, {R, R, R, R});
    lit("reset_fault", {8'd0, fault, fault_code}, 12'd0);
    rst = 1'b1;

    // legal phase cycle
    hold(R, R, R, R, 0, 10);
    hold(Y, R, R, R, 0, 5);
    lit("t1_north_yellow", {n_lamp, e_lamp, s_lamp, w_lamp}, {Y, R, R, R});
    hold(G, R, R, R, 0, 30);
    lit("t1_north_green", {n_lamp, e_lamp, s_lamp, w_lamp}, {G, R, R, R});
    hold(R, Y, R, R, 0, 5);
    hold(R, G, R, R, 0, 30);
    lit("t1_east_green", {n_lamp, e_lamp, s_lamp, w_lamp}, {R, G, R, R});
    hold(R, R, Y, R, 0, 5);
    hold(R, R, G, R, 0, 30);
    hold(R, R, R, Y, 0, 5);
    hold(R, R, R, G, 0, 30);
    lit("t1_west_green", {n_lamp, e_lamp, s_lamp, w_lamp}, {R, R, R, G});
    lit("t1_no_fault", {8'd0, fault, fault_code}, 12'd0);

    // one-sample conflict glitch is masked but not latched
    hold(G, G, R, R, 0, 1);
    hold(G, R, R, R, 0, 1);
    lit("t2_masked", {n_lamp, e_lamp, s_lamp, w_lamp}, {R, R, R, R});
    lit("t2_no_fault", {8'd0, fault, fault_code}, 12'd0);
    hold(G, R, R, R, 0, 1);
    lit("t2_resume", {n_lamp, e_lamp, s_lamp, w_lamp}, {G, R, R, R});
    hold(G, R, R, R, 0, 5);

    // persistent conflict latches code 2 and flashes
    hold(G, G, R, R, 0, 2);
    hold(R, R, R, G, 0, 1);
    lit("t3_fault", {8'd0, fault, fault_code}, {8'd0, 1'b1, 3'd2});
    lit("t3_flash_red0", {n_lamp, e_lamp, s_lamp, w_lamp}, {R, R, R, R});
    hold(R, R, R, G, 0, 7);
    lit("t3_flash_red7", {n_lamp, e_lamp, s_lamp, w_lamp}, {R, R, R, R});
    hold(Y, G, G, Y, 0, 1);
    lit("t3_flash_dark8", {n_lamp, e_lamp, s_lamp, w_lamp}, {D, D, D, D});
    hold(Y, G, G, Y, 0, 7);
    lit("t3_flash_dark15", {n_lamp, e_lamp, s_lamp, w_lamp}, {D, D, D, D});
    hold(R, R, R, G, 0, 1);
    lit("t3_flash_red16", {n_lamp, e_lamp, s_lamp, w_lamp}, {R, R, R, R});

    // clear qualified by all-red, full recovery
    hold(G, R, R, R, 1, 3);
    lit("t5_clear_ignored", {8'd0, fault, fault_code}, {8'd0, 1'b1, 3'd2});
    hold(R, R, R, R, 1, 2);
    clear = 1'b0;
    hold(R, R, R, R, 0, 15);
    lit("t5_recover_hold", {8'd0, fault, fault_code}, {8'd0, 1'b1, 3'd2});
    lit("t5_recover_red", {n_lamp, e_lamp, s_lamp, w_lamp}, {R, R, R, R});
    hold(R, R, R, R, 0, 1);
    lit("t5_recovered", {8'd0, fault, fault_code}, 12'd0);
    hold(R, R, G, R, 0, 3);
    lit("t5_pass_through", {n_lamp, e_lamp, s_lamp, w_lamp}, {R, R, G, R});

    // recovery aborted by an East yellow sample
    hold(R, R, G, Y, 0, 2);
    hold(R, R, R, R, 0, 1);
    lit("t5b_fault", {8'd0, fault, fault_code}, {8'd0, 1'b1, 3'd2});
    hold(R, R, R, R, 1, 1);
    hold(R, R, R, R, 0, 5);
    hold(R, Y, R, R, 0, 2);
    lit("t5b_back_to_fault", {8'd0, fault, fault_code}, {8'd0, 1'b1, 3'd2});
    lit("t5b_flash_restart", {n_lamp, e_lamp, s_lamp, w_lamp}, {R, R, R, R});
    hold(R, R, R, R, 0, 10);
    lit("t5b_flash_dark10", {n_lamp, e_lamp, s_lamp, w_lamp}, {D, D, D, D});

    // async reset mid-flash, then single-cause faults
    do_reset("t6_reset");
    hold(G, R, 3'b011, R, 0, 2);
    hold(R, R, R, R, 0, 1);
    lit("t4_invalid", {8'd0, fault, fault_code}, {8'd0, 1'b1, 3'd1});

    do_reset("t4_reset_go");
    hold(G, R, R, R, 0, 50);
    lit("t4_go_not_yet", {8'd0, fault, fault_code}, 12'd0);
    hold(G, R, R, R, 0, 1);
    lit("t4_go_timeout", {8'd0, fault, fault_code}, {8'd0, 1'b1, 3'd3});
    lit("t4_go_lamps", {n_lamp, e_lamp, s_lamp, w_lamp}, {R, R, R, R});

    do_reset("t4_reset_ar");
    hold(G, R, R, R, 0, 3);
    hold(R, R, R, R, 0, 26);
    lit("t4_allred_not_yet", {8'd0, fault, fault_code}, 12'd0);
    hold(R, R, R, R, 0, 1);
    lit("t4_allred_timeout", {8'd0, fault, fault_code}, {8'd0, 1'b1, 3'd4});

    do_reset("final_reset");
    hold(R, G, R, R, 0, 4);
    lit("final_pass", {n_lamp, e_lamp, s_lamp, w_lamp}, {R, G, R, R});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
